// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the two-requester adder sequencer:
// FSM encoding, default settle time and requester IDs.
package adder_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int   DEF_SETTLE_CYCLES = 2;
   localparam logic REQ0              = 1'b0;
   localparam logic REQ1              = 1'b1;

endpackage

// File: rtl/RippleCarryAdder_32bit.sv
// Plain 32-bit ripple-carry adder; the carry crosses all 32 cells in one
// combinational path, so callers must hold the inputs long enough to resolve.
module RippleCarryAdder_32bit (
   input  logic [31:0] i_in1,
   input  logic [31:0] i_in2,
   input  logic        i_c_in,
   output logic [31:0] o_sum,
   output logic        o_c_out
);

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_bit
         logic w_cin;
         logic w_cout;
         if (gi == 0) begin : g_lsb
            assign w_cin = i_c_in;
         end else begin : g_chain
            assign w_cin = g_bit[gi-1].w_cout;
         end
         assign o_sum[gi] = i_in1[gi] ^ i_in2[gi] ^ w_cin;
         assign w_cout    = (i_in1[gi] & i_in2[gi]) | (w_cin & (i_in1[gi] ^ i_in2[gi]));
      end
   endgenerate

   assign o_c_out = g_bit[31].w_cout;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one ripple adder between two requesters: accept,
// hold operands for SETTLE_CYCLES, capture the result, then hand it back.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_in1,
   input  logic [31:0] req0_in2,
   input  logic        req0_c_in,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_in1,
   input  logic [31:0] req1_in2,
   input  logic        req1_c_in,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_sum,
   output logic        rsp_c_out,
   output logic        rsp_ovf,
   output logic        busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_op_a;
   logic [31:0]      r_op_b;
   logic             r_op_cin;
   logic             r_owner;
   logic             r_last_grant;
   logic [31:0]      r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [31:0]      w_add_sum;
   logic             w_add_cout;
   logic             w_win0;
   logic             w_win1;
   logic             w_accept;
   logic             w_accept_id;
   logic             w_capture;

   // The adder only ever sees the registered operands, never the request ports.
   RippleCarryAdder_32bit u_adder (
      .i_in1   (r_op_a),
      .i_in2   (r_op_b),
      .i_c_in  (r_op_cin),
      .o_sum   (w_add_sum),
      .o_c_out (w_add_cout)
   );

   assign w_win0 = req0_valid && (!req1_valid || (r_last_grant == REQ1));
   assign w_win1 = req1_valid && (!req0_valid || (r_last_grant == REQ0));

   always_comb begin
      w_state_next = r_state;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      w_accept     = 1'b0;
      w_accept_id  = REQ0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req0_ready = w_win0;
            req1_ready = w_win1;
            if (w_win0 || w_win1) begin
               w_accept     = 1'b1;
               w_accept_id  = w_win1 ? REQ1 : REQ0;
               w_state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == LAST_CNT) begin
               w_capture    = 1'b1;
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if ((r_owner == REQ0) ? rsp0_ready : rsp1_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_cin     <= 1'b0;
         r_owner      <= REQ0;
         r_last_grant <= REQ1;
         r_sum        <= '0;
         r_cout       <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op_a       <= (w_accept_id == REQ1) ? req1_in1  : req0_in1;
            r_op_b       <= (w_accept_id == REQ1) ? req1_in2  : req0_in2;
            r_op_cin     <= (w_accept_id == REQ1) ? req1_c_in : req0_c_in;
            r_owner      <= w_accept_id;
            r_last_grant <= w_accept_id;
            r_cnt        <= '0;
         end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_capture) begin
            r_sum  <= w_add_sum;
            r_cout <= w_add_cout;
            r_ovf  <= (r_op_a[31] == r_op_b[31]) && (w_add_sum[31] != r_op_a[31]);
         end
      end
   end

   assign rsp0_valid = (r_state == ST_RESP) && (r_owner == REQ0);
   assign rsp1_valid = (r_state == ST_RESP) && (r_owner == REQ1);
   assign rsp_sum    = r_sum;
   assign rsp_c_out  = r_cout;
   assign rsp_ovf    = r_ovf;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a transaction-level reference
// model checked every cycle plus literal expectations for each vector.
module tb_adder_share_arbiter;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
   logic        req0_c_in = 1'b0, req1_c_in = 1'b0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp_sum;
   logic        rsp_c_out, rsp_ovf, busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   adder_share_arbiter #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_c_in(req0_c_in),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_c_in(req1_c_in),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out), .rsp_ovf(rsp_ovf),
      .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {ovf, c_out, sum[31:0]}.
   function automatic logic [33:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic cin);
      logic [32:0] t;
      logic        v;
      t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      v = (a[31] == b[31]) && (t[31] != a[31]);
      return {v, t};
   endfunction

   // Transaction model: one op in flight; result due SETTLE edges after acceptance.
   logic        m_pending, m_owner, m_last;
   logic [33:0] m_res;
   int          m_age;
   logic        e_rdy0, e_rdy1, e_v0, e_v1;

   always_comb begin
      e_rdy0 = !m_pending && req0_valid && (!req1_valid || m_last);
      e_rdy1 = !m_pending && req1_valid && (!req0_valid || !m_last);
      e_v0   = m_pending && (m_age >= SETTLE) && !m_owner;
      e_v1   = m_pending && (m_age >= SETTLE) && m_owner;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending <= 1'b0;
         m_owner   <= 1'b0;
         m_last    <= 1'b1;
         m_age     <= 0;
         m_res     <= '0;
      end else if (!m_pending) begin
         if (e_rdy0 || e_rdy1) begin
            m_pending <= 1'b1;
            m_owner   <= e_rdy1;
            m_last    <= e_rdy1;
            m_age     <= 0;
            m_res     <= e_rdy1 ? model_add(req1_in1, req1_in2, req1_c_in)
                                : model_add(req0_in1, req0_in2, req0_c_in);
         end
      end else if ((m_age >= SETTLE) && (m_owner ? rsp1_ready : rsp0_ready)) begin
         m_pending <= 1'b0;
      end else begin
         m_age <= m_age + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc busy", busy, m_pending);
         check("cyc req0_ready", req0_ready, e_rdy0);
         check("cyc req1_ready", req1_ready, e_rdy1);
         check("cyc rsp0_valid", rsp0_valid, e_v0);
         check("cyc rsp1_valid", rsp1_valid, e_v1);
         if (e_v0 || e_v1) check("cyc rsp_result", {rsp_ovf, rsp_c_out, rsp_sum}, m_res);
      end
   end

   task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] es, input logic ec,
                         input logic eo, input string tag);
      logic got, seen;
      int   lat;
      @(posedge clk); #2;
      if (id) begin req1_in1 = a; req1_in2 = b; req1_c_in = cin; req1_valid = 1'b1; end
      else    begin req0_in1 = a; req0_in2 = b; req0_c_in = cin; req0_valid = 1'b1; end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
      end
      check({tag, " accept"}, got, 1'b1);
      @(posedge clk); #2;
      // operands must have been sampled at acceptance; scramble them now
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_in1 = $urandom; req0_in2 = $urandom; req1_in1 = $urandom; req1_in2 = $urandom;
      lat = 1; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = id ? rsp1_valid : rsp0_valid;
         if (!seen) lat++;
      end
      check({tag, " latency"}, lat, 3);
      check({tag, " sum"}, rsp_sum, es);
      check({tag, " c_out"}, rsp_c_out, ec);
      check({tag, " ovf"}, rsp_ovf, eo);
      check({tag, " other_valid"}, id ? rsp0_valid : rsp1_valid, 1'b0);
      $display("[TB] op %s req%0d %h+%h+%0d -> sum=%h c=%0d v=%0d lat=%0d",
               tag, id, a, b, cin, rsp_sum, rsp_c_out, rsp_ovf, lat);
      @(posedge clk); #2;
      if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(posedge clk); #2;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   order[$];
      logic seen;
      // reset values
      #3;
      check("rst busy", busy, 1'b0);
      check("rst rsp0_valid", rsp0_valid, 1'b0);
      check("rst rsp1_valid", rsp1_valid, 1'b0);
      check("rst rsp_sum", rsp_sum, 32'd0);
      check("rst flags", {rsp_c_out, rsp_ovf}, 2'b00);
      check("rst readys", {req0_ready, req1_ready}, 2'b00);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      run_op(1'b0, 32'd12345678, 32'd98765432, 1'b0, 32'd111111110, 1'b0, 1'b0, "add0");
      run_op(1'b1, 32'd12345678, 32'd98765432, 1'b1, 32'd111111111, 1'b0, 1'b0, "add1_cin");
      run_op(1'b1, 32'hFF439EB2, 32'd98765432, 1'b0, 32'd86419754, 1'b1, 1'b0, "neg1");
      run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "ovf0");
      run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "wrap0");

      // both requesters held valid from reset: strict alternation starting with 0
      do_reset();
      req0_in1 = 32'd100;  req0_in2 = 32'd200;  req0_c_in = 1'b0;
      req1_in1 = 32'd1000; req1_in2 = 32'd2000; req1_c_in = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 60 && order.size() < 4; i++) begin
         @(negedge clk);
         if (req0_ready) order.push_back(0);
         if (req1_ready) order.push_back(1);
      end
      @(posedge clk); #2;
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("rr grants", order.size(), 4);
      for (int k = 0; k < order.size(); k++) begin
         check("rr order", order[k], k % 2);
         $display("[TB] rr grant %0d -> req%0d", k, order[k]);
      end
      repeat (6) @(posedge clk);
      #2 rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // response back-pressure with the other requester waiting
      req0_in1 = 32'd5; req0_in2 = 32'd6; req0_c_in = 1'b0; req0_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
      @(posedge clk); #2;
      req0_valid = 1'b0;
      req1_in1 = 32'd7; req1_in2 = 32'd8; req1_c_in = 1'b0; req1_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rsp0_valid; end
      check("hold rsp0_valid", seen, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("hold sum", rsp_sum, 32'd11);
         check("hold req1_ready", req1_ready, 1'b0);
         check("hold busy", busy, 1'b1);
         $display("[TB] hold cycle %0d sum=%0d busy=%0d", i, rsp_sum, busy);
         @(negedge clk);
      end
      @(posedge clk); #2;
      rsp0_ready = 1'b1;
      req0_in1 = 32'd9; req0_in2 = 32'd10; req0_valid = 1'b1;
      @(posedge clk); #2;
      rsp0_ready = 1'b0;
      @(negedge clk);
      check("release busy", busy, 1'b0);
      check("b2b req1_ready", req1_ready, 1'b1);
      check("b2b req0_ready", req0_ready, 1'b0);
      @(posedge clk); #2;
      req0_valid = 1'b0; req1_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = rsp1_valid; end
      check("b2b rsp1_valid", seen, 1'b1);
      check("b2b sum", rsp_sum, 32'd15);
      $display("[TB] b2b req1 sum=%0d", rsp_sum);
      @(posedge clk); #2 rsp1_ready = 1'b1;
      @(posedge clk); #2 rsp1_ready = 1'b0;

      // reset while an operation is settling
      req0_in1 = 32'd1; req0_in2 = 32'd2; req0_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
      @(posedge clk); #2;
      req0_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
      check("abort rsp_sum", rsp_sum, 32'd0);
      check("abort flags", {rsp_c_out, rsp_ovf}, 2'b00);
      $display("[TB] reset mid-settle busy=%0d sum=%0d", busy, rsp_sum);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post-reset quiet", {rsp0_valid, rsp1_valid, busy}, 3'b000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Sequencing controller that shares one RippleCarryAdder_32bit instance between two requesters. It runs a round-robin arbiter with valid/ready handshakes and latches the winner's operands into registers. It then holds them stable for a parameterised number of settle cycles, so the long ripple chain resolves, before capturing the result. It sits between two client blocks (e.g. ALU ops and address generation) and the single shared adder.

Parameters:
SETTLE_CYCLES, 2, cycles operands are held on the adder before capture; legal range 1..15
CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_in1  input  32  requester 0 operand A
req0_in2  input  32  requester 0 operand B
req0_c_in  input  1  requester 0 carry-in
req1_valid / req1_ready / req1_in1 / req1_in2 / req1_c_in  as above, requester 1
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 takes result
rsp1_valid  output  1  result for requester 1 available
rsp1_ready  input  1  requester 1 takes result
rsp_sum  output  32  registered sum (shared bus, qualified by rspN_valid)
rsp_c_out  output  1  registered carry-out
rsp_ovf  output  1  registered signed overflow
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. All state resets immediately on rst_n low.
- Reset values: state=IDLE, all readys/valids 0, rsp_sum=0, rsp_c_out=0, rsp_ovf=0, busy=0, settle counter=0, operand registers=0, owner=0, last_grant=1 (so requester 0 wins the first tie).
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - reqN_ready is combinational. It is high only for the arbitration winner among asserted reqN_valid.
  - Only one requester valid: that requester wins.
  - Both valid: the winner is the requester other than last_grant.
  - On valid&ready: latch in1/in2/c_in into operand registers, set owner, update last_grant, clear counter, go to SETTLE.
  - If neither is valid, stay in IDLE.
- SETTLE:
  - The adder's inputs are driven only from the operand registers, never directly from request ports.
  - The counter increments each cycle.
  - When counter == SETTLE_CYCLES-1: capture adder sum and c_out into the rsp registers, compute ovf, go to RESP.
  - Both readys are 0.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid stays 0.
  - Result registers hold stable.
  - On rsp<owner>_ready: go to IDLE.
  - rspN_ready for the non-owner is ignored.
- Latency: acceptance edge → rsp valid after SETTLE_CYCLES+1 edges. With SETTLE_CYCLES=2, a response on every requester is visible 3 cycles after acceptance.
- Throughput: a new acceptance is possible in the cycle after the response handshake (IDLE re-entry). Peak rate is one op per SETTLE_CYCLES+2 cycles.
- Arithmetic:
  - sum = in1 + in2 + c_in, modulo 2^32; c_out is bit 32.
  - ovf = (in1[31]==in2[31]) && (sum[31]!=in1[31]).
- Boundary conditions:
  - Requests arriving during SETTLE/RESP wait; valid must be held by the requester, and the operands are sampled only at acceptance.
  - Request valid dropping before acceptance is legal.
  - A same-requester back-to-back request in the IDLE cycle after its response still respects round-robin if the other requester is waiting.
  - Reset mid-SETTLE or mid-RESP aborts the operation; no response is issued after reset release.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SETTLE=2'd1, RESP=2'd2), default SETTLE_CYCLES, requester ID constants.
- One sub-module: RippleCarryAdder_32bit (existing block), instantiated once as the shared datapath.
- Arbitration and FSM stay in this module.

Test Plan:
- req0: 12345678 + 98765432, c_in=0 → rsp0_valid 3 cycles after accept; sum=111111110, c_out=0, ovf=0.
- req1: 12345678 + 98765432, c_in=1 → sum=111111111; then req1: -12345678 + 98765432, c_in=0 → sum=86419754, c_out=1, ovf=0.
- req0: 32'h7FFFFFFF + 32'h00000001 → sum=32'h80000000, c_out=0, ovf=1; 32'hFFFFFFFF + 1 → sum=0, c_out=1, ovf=0.
- Both valid from reset, held → grant order 0,1,0,1; each rsp goes only to the matching rspN_valid.
- rsp0_ready held low for 5 cycles in RESP → rsp_sum stable, req1_ready stays 0, busy=1; release → IDLE next cycle.
- Assert rst_n=0 during SETTLE → all outputs at reset values immediately; no rsp_valid after release without a new request.
